// File: rtl/result_writeback_pkg.sv
`default_nettype none
//==============================================================================
// result_writeback_pkg : shared types and constants for the result write-back
// Revision 1.0
//==============================================================================
package result_writeback_pkg;

  localparam int WB_ADDR_W      = 32;
  localparam int WB_DATA_W      = 32;
  localparam int ELEM_COL_BYTES = 4;
  localparam int TILE_COL_BYTES = 8;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    E11 = 2'd0,
    E12 = 2'd1,
    E21 = 2'd2,
    E22 = 2'd3
  } elem_e;

endpackage
`default_nettype wire

// File: rtl/wb_tile_addr_gen.sv
`default_nettype none
//==============================================================================
// wb_tile_addr_gen : incremental row-major address tracker for one element
// Revision 1.0
//==============================================================================
module wb_tile_addr_gen
  import result_writeback_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              advance,
  input  logic [15:0]       tiles_x,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [ADDR_W-1:0] elem_off,
  output logic [ADDR_W-1:0] addr
);

  logic [15:0]       r_last_col;
  logic [15:0]       r_col;
  logic [ADDR_W-1:0] r_row_step;
  logic [ADDR_W-1:0] r_row_start;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_start_addr;

  assign w_start_addr = base_addr + elem_off;
  assign addr         = r_addr;

  // r_row_start remembers the first column of the current tile-row so a wrap
  // needs only one add of the two-row step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_col  <= '0;
      r_col       <= '0;
      r_row_step  <= '0;
      r_row_start <= '0;
      r_addr      <= '0;
    end else if (start) begin
      r_last_col  <= (tiles_x == 16'd0) ? 16'd0 : tiles_x - 16'd1;
      r_col       <= '0;
      r_row_step  <= {row_stride[ADDR_W-2:0], 1'b0};
      r_row_start <= w_start_addr;
      r_addr      <= w_start_addr;
    end else if (advance) begin
      if (r_col == r_last_col) begin
        r_col       <= '0;
        r_row_start <= r_row_start + r_row_step;
        r_addr      <= r_row_start + r_row_step;
      end else begin
        r_col  <= r_col + 16'd1;
        r_addr <= r_addr + ADDR_W'(TILE_COL_BYTES);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_writeback.sv
`default_nettype none
//==============================================================================
// result_writeback : buffers 2x2 result tiles and writes them over OBI.
// Optional WB_PERF_COUNTERS_EN adds stall/peak-fill counters. Revision 1.0
//==============================================================================
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [15:0]       tiles_x,
  input  logic [15:0]       tiles_total,
  input  logic [DATA_W-1:0] C11,
  input  logic [DATA_W-1:0] C12,
  input  logic [DATA_W-1:0] C21,
  input  logic [DATA_W-1:0] C22,
  input  logic              c11ready,
  input  logic              c12ready,
  input  logic              c21ready,
  input  logic              c22ready,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef WB_PERF_COUNTERS_EN
  , output logic [31:0]                  stall_cycles
  , output logic [$clog2(FIFO_DEPTH):0]  peak_fill
`endif
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic               r_busy;
  logic               r_done;
  logic               r_overflow;
  logic [15:0]        r_tiles_total;
  logic [17:0]        r_write_cnt;
  entry_t             r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic [3:0]         w_strobe;
  logic [3:0]         w_acc;
  logic [3:0]         w_we;
  logic [DATA_W-1:0]  w_cdata     [4];
  logic [ADDR_W-1:0]  w_off       [4];
  logic [ADDR_W-1:0]  w_elem_addr [4];
  logic [c_PTR_W-1:0] w_widx      [4];
  logic               w_pop;
  logic               w_drop;
  logic [c_CNT_W-1:0] w_slots;
  logic [c_CNT_W-1:0] w_npush;
  entry_t             w_head;

  assign w_strobe = {c22ready, c21ready, c12ready, c11ready};
  assign w_acc    = w_strobe & {4{r_busy & ~start}};

  assign w_cdata[E11] = C11;
  assign w_cdata[E12] = C12;
  assign w_cdata[E21] = C21;
  assign w_cdata[E22] = C22;

  assign w_off[E11] = '0;
  assign w_off[E12] = ADDR_W'(ELEM_COL_BYTES);
  assign w_off[E21] = row_stride;
  assign w_off[E22] = row_stride + ADDR_W'(ELEM_COL_BYTES);

  for (genvar g = 0; g < 4; g++) begin : g_addr
    wb_tile_addr_gen #(
      .ADDR_W (ADDR_W)
    ) u_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .advance    (w_acc[g]),
      .tiles_x    (tiles_x),
      .base_addr  (base_addr),
      .row_stride (row_stride),
      .elem_off   (w_off[g]),
      .addr       (w_elem_addr[g])
    );
  end

  // C22 claims the first free slot: it belongs to the oldest tile in flight.
  always_comb begin
    w_pop   = (r_count != '0) & mem_gnt;
    w_slots = c_CNT_W'(FIFO_DEPTH) - r_count + c_CNT_W'(w_pop);
    w_npush = '0;
    w_drop  = 1'b0;
    w_we    = '0;
    for (int i = 3; i >= 0; i--) begin
      w_widx[i] = r_wr_ptr + w_npush[c_PTR_W-1:0];
      if (w_acc[i]) begin
        if (w_npush < w_slots) begin
          w_we[i] = 1'b1;
          w_npush = w_npush + c_CNT_W'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (start) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop);
      r_wr_ptr <= r_wr_ptr + w_npush[c_PTR_W-1:0];
      r_count  <= r_count + w_npush - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_we[i]) begin
        r_mem[w_widx[i]] <= '{addr: w_elem_addr[i], data: w_cdata[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_tiles_total <= '0;
      r_write_cnt   <= '0;
    end else if (start) begin
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_tiles_total <= tiles_total;
      r_write_cnt   <= '0;
    end else begin
      if (w_pop) begin
        r_write_cnt <= r_write_cnt + 18'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (r_busy && (r_write_cnt == {r_tiles_total, 2'b00})) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign mem_req   = (r_count != '0);
  assign mem_addr  = mem_req ? w_head.addr : '0;
  assign mem_wdata = mem_req ? w_head.data : '0;
  assign mem_we    = 1'b1;
  assign mem_be    = 4'hF;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;

`ifdef WB_PERF_COUNTERS_EN
  logic [31:0]        r_stall_cycles;
  logic [c_CNT_W-1:0] r_peak_fill;

  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      r_stall_cycles <= '0;
      r_peak_fill    <= '0;
    end else begin
      if (mem_req && !mem_gnt && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (r_count > r_peak_fill) begin
        r_peak_fill <= r_count;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign peak_fill    = r_peak_fill;
`endif

endmodule
`default_nettype wire
